// File: rtl/work_arbiter.sv
// Round-robin arbiter sharing one worker engine among N_REQ requesters.
// Optional job watchdog is built in when WORK_ARB_TIMEOUT_EN is defined.
module work_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             work_begin,
    input  logic             work_end,
    output logic [N_REQ-1:0] done,
    output logic             busy
`ifdef WORK_ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [3:0] {
        IDLE  = 4'h1,
        GRANT = 4'h2,
        WORK  = 4'h4,
        DONE  = 4'h8
    } state_t;

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("work_arbiter: N_REQ must be 2..16 and TIMEOUT_CYC at least 1");
    end

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, winner, pick;
    logic             pick_vld;
    logic             expired;

    // First set request at or after ptr, wrapping past the top index.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_c;
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        idx_c    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_c = IDX_W'(idx);
            if (!pick_vld && req[idx_c]) begin
                pick_vld = 1'b1;
                pick     = idx_c;
            end
        end
    end

`ifdef WORK_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    // cnt counts finished WORK cycles, so the limit fires at the end of cycle TIMEOUT_CYC.
    assign expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else if (state == GRANT) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else if (state == WORK) begin
            cnt       <= cnt + 1'b1;
            timed_out <= expired && !work_end;
        end
    end

    assign timeout = (state == DONE) && timed_out;
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        grant      = '0;
        done       = '0;
        work_begin = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pick_vld) state_nxt = GRANT;
            end
            GRANT: begin
                grant[winner] = 1'b1;
                work_begin    = 1'b1;
                state_nxt     = WORK;
            end
            WORK: begin
                grant[winner] = 1'b1;
                if (work_end || expired) state_nxt = DONE;
            end
            DONE: begin
                grant[winner] = 1'b1;
                done[winner]  = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) winner <= pick;
            if (state == DONE) ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule
